gated_vco_voice: RTL and testbench



---
 rtl/discrete_pkg.sv | 33 +++
 rtl/phase_accumulator_vco.sv | 25 ++
 rtl/gated_vco_voice.sv | 182 ++++++++++++++++++
 tb/tb_gated_vco_voice.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// Shared constants, envelope state type and the control-voltage mixer helper
// for the gated VCO voice.
package discrete_pkg;

    // 5 V expressed in the voice's 16-bit fixed-point control scale
    localparam int unsigned FIVE_VOLT  = 6826;
    localparam int unsigned ENV_MAX    = 32767;
    localparam int unsigned PHASE_W    = 24;

    // Resistor-mixer weights; the /22 is a reciprocal multiply (2979/65536)
    localparam int unsigned MIX_GATE_W = 10;
    localparam int unsigned MIX_LFO_W  = 12;
    localparam int unsigned MIX_RECIP  = 2979;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_DECAY   = 2'd3
    } env_state_t;

    // Weighted sum of gate and LFO voltages divided by 22, computed on 32 bits
    // and truncated to 16; exact for every gate/LFO combination that occurs.
    function automatic logic [15:0] mix_control(input logic gate_on, input logic lfo_on);
        logic [31:0] weighted;
        logic [31:0] scaled;
        weighted = (gate_on ? 32'(FIVE_VOLT * MIX_GATE_W) : 32'd0)
                 + (lfo_on  ? 32'(FIVE_VOLT * MIX_LFO_W)  : 32'd0);
        scaled   = weighted * 32'(MIX_RECIP);
        return scaled[31:16];
    endfunction

endpackage

// File: rtl/phase_accumulator_vco.sv
// 24-bit phase accumulator oscillator; the MSB is the square-wave output.
module phase_accumulator_vco
    import discrete_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               audio_clk_en,
    input  logic [PHASE_W-1:0] inc,
    output logic               phase_msb
);

    logic [PHASE_W-1:0] phase;

    // Advance the phase once per audio sample, wrapping modulo 2^24
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (audio_clk_en) begin
            phase <= phase + inc;
        end
    end

    assign phase_msb = phase[PHASE_W-1];

endmodule

// File: rtl/gated_vco_voice.sv
// Gated VCO voice: square LFO and gate mixed into a control voltage that
// modulates a phase-accumulator VCO, shaped by an attack/sustain/decay envelope.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ENV_IDLE    | silent, waiting for a trig_n falling edge
// ENV_ATTACK  | level rising by ATTACK_STEP per sample up to ENV_MAX
// ENV_SUSTAIN | gated mode, holding ENV_MAX while trig_n stays low
// ENV_DECAY   | level falling by DECAY_STEP per sample; retriggerable
module gated_vco_voice
    import discrete_pkg::*;
#(
    parameter int CLOCK_RATE       = 1000000,
    parameter int SAMPLE_RATE      = 48000,
    parameter int WIDTH            = 16,
    parameter int LFO_HALF_SAMPLES = 120,
    parameter int VCO_BASE_INC     = 3000,
    parameter int VCO_SPAN_INC     = 2000,
    parameter int ATTACK_STEP      = 1024,
    parameter int DECAY_STEP       = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    audio_clk_en,
    input  logic                    trig_n,
    input  logic                    one_shot,
    output logic signed [WIDTH-1:0] out,
    output logic                    busy
);

    localparam int LFO_W = (LFO_HALF_SAMPLES > 1) ? $clog2(LFO_HALF_SAMPLES) : 1;
    localparam logic [LFO_W-1:0] LFO_LAST = LFO_W'(LFO_HALF_SAMPLES - 1);

    // Reject parameter sets the datapath is not sized for
    if (WIDTH < 12 || WIDTH > 24) begin : g_bad_width
        $error("gated_vco_voice: WIDTH must be within 12..24");
    end
    if (LFO_HALF_SAMPLES < 1) begin : g_bad_lfo
        $error("gated_vco_voice: LFO_HALF_SAMPLES must be at least 1");
    end
    if (SAMPLE_RATE > CLOCK_RATE) begin : g_bad_rate
        $error("gated_vco_voice: SAMPLE_RATE cannot exceed CLOCK_RATE");
    end

    logic [LFO_W-1:0]   lfo_cnt;
    logic               lfo_level;
    logic [15:0]        control;
    logic [31:0]        span_prod;
    logic [PHASE_W-1:0] vco_inc;
    logic               vco_high;

    env_state_t         state, next_state;
    logic [15:0]        level, next_level;
    logic               os_latched, next_os;
    logic               prev_trig;
    logic               trig_fall;
    logic [16:0]        atk_sum;

    logic signed [16:0]      env_sample;
    logic signed [WIDTH-1:0] scaled;

    // LFO half-period counter; the square output flips on every wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            lfo_cnt   <= '0;
            lfo_level <= 1'b0;
        end else if (audio_clk_en) begin
            if (lfo_cnt == LFO_LAST) begin
                lfo_cnt   <= '0;
                lfo_level <= ~lfo_level;
            end else begin
                lfo_cnt <= lfo_cnt + 1'b1;
            end
        end
    end

    // Control voltage and the VCO increment it produces
    always_comb begin
        control   = mix_control(~trig_n, lfo_level);
        span_prod = {16'd0, control} * 32'(VCO_SPAN_INC);
        vco_inc   = PHASE_W'(VCO_BASE_INC) + {6'd0, span_prod[31:14]};
    end

    phase_accumulator_vco u_vco (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .inc          (vco_inc),
        .phase_msb    (vco_high)
    );

    // A trigger is a high-to-low step of trig_n between consecutive samples
    assign trig_fall = prev_trig & ~trig_n;
    assign atk_sum   = {1'b0, level} + 17'(ATTACK_STEP);

    // Envelope next-state and next-level logic
    always_comb begin
        next_state = state;
        next_level = level;
        next_os    = os_latched;
        case (state)
            ENV_IDLE: begin
                if (trig_fall) begin
                    next_state = ENV_ATTACK;
                    next_os    = one_shot;
                end
            end
            ENV_ATTACK: begin
                if (atk_sum >= 17'(ENV_MAX)) begin
                    next_level = 16'(ENV_MAX);
                    next_state = os_latched ? ENV_DECAY : ENV_SUSTAIN;
                end else begin
                    next_level = atk_sum[15:0];
                end
            end
            ENV_SUSTAIN: begin
                if (trig_n) begin
                    next_state = ENV_DECAY;
                end
            end
            ENV_DECAY: begin
                // Retrigger keeps the current level so the attack is click-free
                if (trig_fall) begin
                    next_state = ENV_ATTACK;
                    next_os    = one_shot;
                end else if (level <= 16'(DECAY_STEP)) begin
                    next_level = '0;
                    next_state = ENV_IDLE;
                end else begin
                    next_level = level - 16'(DECAY_STEP);
                end
            end
            default: begin
                next_state = ENV_IDLE;
                next_level = '0;
            end
        endcase
    end

    // Envelope state register; prev_trig starts high so reset never looks like a trigger
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ENV_IDLE;
            level      <= '0;
            os_latched <= 1'b0;
            prev_trig  <= 1'b1;
        end else if (audio_clk_en) begin
            state      <= next_state;
            level      <= next_level;
            os_latched <= next_os;
            prev_trig  <= trig_n;
        end
    end

    // Envelope-modulated square wave on 17 signed bits
    always_comb begin
        env_sample = vco_high ? $signed({1'b0, level}) : -$signed({1'b0, level});
    end

    if (WIDTH >= 16) begin : g_widen
        assign scaled = $signed(WIDTH'(env_sample)) <<< (WIDTH - 16);
    end else begin : g_narrow
        localparam int S_MAX = (1 << (WIDTH - 1)) - 1;
        localparam int S_MIN = -(1 << (WIDTH - 1));
        logic signed [16:0] shr;
        assign shr    = env_sample >>> (16 - WIDTH);
        assign scaled = (shr > 17'(S_MAX)) ? WIDTH'(S_MAX) :
                        (shr < 17'(S_MIN)) ? WIDTH'(S_MIN) : WIDTH'(shr);
    end

    // Output register; forced to zero on the same sample the envelope goes idle
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (audio_clk_en) begin
            out <= (next_state == ENV_IDLE) ? '0 : scaled;
        end
    end

    assign busy = (state != ENV_IDLE);

endmodule

// File: tb/tb_gated_vco_voice.sv
// Self-checking bench for gated_vco_voice: directed scenarios plus randomized
// gate traffic compared against a per-sample behavioural model.
module tb_gated_vco_voice;

    localparam int WIDTH = 16;
    localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_DEC = 3;
    localparam int TWO24 = 16777216;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic audio_clk_en = 1'b0;
    logic trig_n = 1'b1;
    logic one_shot = 1'b0;
    logic signed [WIDTH-1:0] out;
    logic busy;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int m_state, m_level, m_phase, m_cnt, m_out;
    bit m_lfo, m_prev, m_os;

    always #5 clk = ~clk;

    gated_vco_voice dut (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .trig_n       (trig_n),
        .one_shot     (one_shot),
        .out          (out),
        .busy         (busy)
    );

    function automatic void model_reset();
        m_state = M_IDLE; m_level = 0; m_phase = 0; m_cnt = 0; m_out = 0;
        m_lfo = 0; m_prev = 1; m_os = 0;
    endfunction

    // One audio sample of the voice, straight from the behavioural rules
    function automatic void model_step(input bit t, input bit os);
        int ctl, inc, nstate, nlevel;
        bit hi, fall;
        ctl    = ((t ? 0 : 6826) * 10 + (m_lfo ? 6826 : 0) * 12) / 22;
        inc    = 3000 + (ctl * 2000) / 16384;
        hi     = (m_phase >= TWO24 / 2);
        fall   = m_prev && !t;
        nstate = m_state;
        nlevel = m_level;
        case (m_state)
            M_IDLE: if (fall) begin nstate = M_ATK; m_os = os; end
            M_ATK: begin
                if (m_level + 1024 >= 32767) begin
                    nlevel = 32767;
                    nstate = m_os ? M_DEC : M_SUS;
                end else nlevel = m_level + 1024;
            end
            M_SUS: if (t) nstate = M_DEC;
            default: begin
                if (fall) begin nstate = M_ATK; m_os = os; end
                else if (m_level <= 64) begin nlevel = 0; nstate = M_IDLE; end
                else nlevel = m_level - 64;
            end
        endcase
        m_out   = (nstate == M_IDLE) ? 0 : (hi ? m_level : -m_level);
        m_phase = (m_phase + inc) % TWO24;
        if (m_cnt == 119) begin m_cnt = 0; m_lfo = !m_lfo; end
        else m_cnt = m_cnt + 1;
        m_prev  = t;
        m_state = nstate;
        m_level = nlevel;
    endfunction

    // Drive one strobe with the given inputs, then idle for 'gap' cycles
    task automatic strobe(input bit t, input bit os, input int gap);
        @(negedge clk);
        trig_n = t; one_shot = os; audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        model_step(t, os);
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; audio_clk_en = 1'b0; trig_n = 1'b1; one_shot = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++; if (int'(out) !== 0) begin failures++; $display("FAIL reset_out actual=%0d required=0", out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (int'(dut.level) !== 0) begin failures++; $display("FAIL reset_level actual=%0d required=0", dut.level); end
        checks++; if (int'(dut.u_vco.phase) !== 0) begin failures++; $display("FAIL reset_phase actual=%0d required=0", dut.u_vco.phase); end
    endtask

    task automatic test_vco_inc();
        int p, n;
        for (int k = 1; k <= 5; k++) begin
            strobe(1'b1, 1'b0, 0);
            checks++;
            if (int'(dut.u_vco.phase) !== 3000 * k) begin
                failures++; $display("FAIL vco_base_inc k=%0d actual=%0d required=%0d", k, dut.u_vco.phase, 3000 * k);
            end
        end
        for (int k = 6; k <= 120; k++) strobe(1'b1, 1'b0, $urandom_range(0, 2));
        checks++;
        if (int'(dut.u_vco.phase) !== m_phase) begin
            failures++; $display("FAIL vco_lfo_phase actual=%0d required=%0d", dut.u_vco.phase, m_phase);
        end
        // LFO is now high; pulling the gate low gives full-scale control
        for (int k = 0; k < 3; k++) begin
            p = m_phase;
            strobe(1'b0, 1'b0, 0);
            checks++;
            if (int'(dut.u_vco.phase) !== (p + 3833) % TWO24) begin
                failures++; $display("FAIL vco_full_inc actual=%0d required=%0d", dut.u_vco.phase, (p + 3833) % TWO24);
            end
        end
        n = 0;
        while (m_state != M_IDLE && n < 2000) begin strobe(1'b1, 1'b0, 0); n++; end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL vco_tail_idle actual=%b required=0", busy); end
    endtask

    task automatic test_gated();
        int atk_n, rel_n;
        atk_n = -1;
        for (int i = 0; i < 100; i++) begin
            strobe(1'b0, 1'b0, $urandom_range(0, 2));
            if (atk_n < 0 && int'(dut.level) == 32767) atk_n = i;
            checks++;
            if (int'(out) !== m_out || busy !== 1'b1) begin
                failures++; $display("FAIL gated_sample i=%0d out=%0d busy=%b required out=%0d busy=1", i, out, busy, m_out);
            end
        end
        checks++;
        if (atk_n !== (32767 + 1023) / 1024) begin
            failures++; $display("FAIL gated_attack_len actual=%0d required=%0d", atk_n, (32767 + 1023) / 1024);
        end
        checks++;
        if (int'(dut.level) !== 32767) begin failures++; $display("FAIL gated_sustain_level actual=%0d required=32767", dut.level); end
        rel_n = 0;
        while (busy && rel_n < 2000) begin
            strobe(1'b1, 1'b0, $urandom_range(0, 1));
            rel_n++;
            checks++;
            if (int'(out) !== m_out) begin
                failures++; $display("FAIL gated_release_out n=%0d actual=%0d required=%0d", rel_n, out, m_out);
            end
        end
        checks++;
        if (rel_n !== 1 + (32767 + 63) / 64) begin
            failures++; $display("FAIL gated_release_len actual=%0d required=%0d", rel_n, 1 + (32767 + 63) / 64);
        end
        checks++;
        if (int'(out) !== 0 || int'(dut.level) !== 0) begin
            failures++; $display("FAIL gated_idle_out out=%0d level=%0d required=0", out, dut.level);
        end
    endtask

    task automatic test_one_shot();
        int n;
        strobe(1'b0, 1'b1, 0);
        n = 1;
        while (busy && n < 3000) begin
            strobe(1'b1, 1'($urandom_range(0, 1)), 0);
            n++;
            checks++;
            if (int'(out) !== m_out || int'(dut.level) !== m_level) begin
                failures++; $display("FAIL one_shot_sample n=%0d out=%0d level=%0d required out=%0d level=%0d", n, out, dut.level, m_out, m_level);
            end
        end
        checks++;
        if (n !== 1 + 32 + 512) begin failures++; $display("FAIL one_shot_busy_len actual=%0d required=%0d", n, 1 + 32 + 512); end
    endtask

    task automatic test_retrigger();
        int lvl, n, need;
        strobe(1'b0, 1'b1, 0);
        n = 0;
        while (!(m_state == M_DEC && m_level <= 16000) && n < 2000) begin strobe(1'b1, 1'b1, 0); n++; end
        lvl = m_level;
        strobe(1'b0, 1'b1, 0);
        checks++;
        if (int'(dut.level) !== lvl || busy !== 1'b1) begin
            failures++; $display("FAIL retrig_keeps_level actual=%0d required=%0d", dut.level, lvl);
        end
        need = (32767 - lvl + 1023) / 1024;
        n = 0;
        while (int'(dut.level) != 32767 && n < 100) begin strobe(1'b0, 1'b1, 0); n++; end
        checks++;
        if (n !== need) begin failures++; $display("FAIL retrig_attack_len actual=%0d required=%0d", n, need); end
        n = 0;
        while (busy && n < 2000) begin strobe(1'b1, 1'b1, 0); n++; end
        checks++;
        if (busy !== 1'b0 || int'(out) !== 0) begin failures++; $display("FAIL retrig_tail busy=%b out=%0d required 0", busy, out); end
    endtask

    task automatic test_hold();
        strobe(1'b0, 1'b1, 0);
        for (int k = 0; k < 10; k++) strobe(1'b1, 1'b1, 0);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            trig_n = 1'($urandom_range(0, 1));
            one_shot = 1'($urandom_range(0, 1));
            if (c == 499 || c == 999) begin
                checks++;
                if (int'(out) !== m_out || int'(dut.level) !== m_level || int'(dut.u_vco.phase) !== m_phase || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_no_strobe c=%0d out=%0d level=%0d phase=%0d busy=%b required out=%0d level=%0d phase=%0d busy=1",
                             c, out, dut.level, dut.u_vco.phase, busy, m_out, m_level, m_phase);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            strobe(1'b1, 1'b0, 0);
            checks++;
            if (int'(out) !== m_out || int'(dut.level) !== m_level) begin
                failures++; $display("FAIL hold_resume out=%0d level=%0d required out=%0d level=%0d", out, dut.level, m_out, m_level);
            end
        end
    endtask

    task automatic test_reset_mid_decay();
        int n;
        n = 0;
        while (!(m_state == M_DEC && m_level <= 5000) && n < 2000) begin strobe(1'b1, 1'b1, 0); n++; end
        checks++;
        if (busy !== 1'b1 || int'(dut.level) !== m_level) begin
            failures++; $display("FAIL pre_reset_decay busy=%b level=%0d required busy=1 level=%0d", busy, dut.level, m_level);
        end
        @(negedge clk);
        trig_n = 1'b0; reset = 1'b1; audio_clk_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (int'(out) !== 0 || busy !== 1'b0 || int'(dut.level) !== 0) begin
            failures++; $display("FAIL reset_mid_decay out=%0d busy=%b level=%0d required 0 0 0", out, busy, dut.level);
        end
        strobe(1'b0, 1'b0, 0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL post_reset_trigger actual=%b required=1", busy); end
        n = 0;
        while (m_state != M_IDLE && n < 2000) begin strobe(1'b1, 1'b0, 0); n++; end
    endtask

    task automatic test_random();
        bit t;
        t = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) t = !t;
            strobe(t, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            checks++;
            if (int'(out) !== m_out || busy !== (m_state != M_IDLE) || int'(dut.level) !== m_level) begin
                failures++;
                $display("FAIL random_sample i=%0d out=%0d busy=%b level=%0d required out=%0d busy=%0d level=%0d",
                         i, out, busy, dut.level, m_out, (m_state != M_IDLE), m_level);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_vco_inc();
        test_gated();
        test_one_shot();
        test_retrigger();
        test_hold();
        test_reset_mid_decay();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
